// File: rtl/fifo_mst_io_reg.sv
// Registered pad ring for the FT600/FT601 245-style synchronous FIFO master.
// Every pad input and output passes through a flop. A direction FSM inserts
// hi-Z turnaround cycles between FPGA-driven and chip-driven bus phases, and
// strobes that would fight the bus direction are forced high and flagged.
module fifo_mst_io_reg #(
  parameter int WIDTH_DATA = 32,
  parameter int TURN_CYC   = 1,
  parameter int IN_STAGES  = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  inout  wire  [WIDTH_DATA-1:0]   DATA,
  inout  wire  [WIDTH_DATA/8-1:0] BE,
  input  logic                    TXE_N,
  input  logic                    RXF_N,
  output logic                    SIWU_N,
  output logic                    WR_N,
  output logic                    RD_N,
  output logic                    OE_N,
  input  logic [WIDTH_DATA-1:0]   tp_data,
  input  logic [WIDTH_DATA/8-1:0] tp_be,
  input  logic                    tp_drv_req,
  input  logic                    tp_siwu_n,
  input  logic                    tp_wr_n,
  input  logic                    tp_rd_n,
  input  logic                    tp_oe_n,
  output logic [WIDTH_DATA-1:0]   tc_data,
  output logic [WIDTH_DATA/8-1:0] tc_be,
  output logic                    tc_txe_n,
  output logic                    tc_rxf_n,
  output logic                    tc_drv_ack,
  output logic                    tc_turn,
  output logic                    tc_conflict
);

  localparam int CNT_BE = WIDTH_DATA / 8;
  localparam int IN_W   = WIDTH_DATA + CNT_BE + 2;
  // Status pads idle high, data/BE idle low.
  localparam logic [IN_W-1:0] IN_RST   = {2'b11, {(IN_W-2){1'b0}}};
  localparam logic [1:0]      CNT_LOAD = 2'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } state_t;

  state_t                 state;
  logic [1:0]             cnt;
  logic                   drive;
  logic [WIDTH_DATA-1:0]  dout;
  logic [CNT_BE-1:0]      be_out;
  logic [IN_W-1:0]        in_pipe [IN_STAGES];

  // Direction FSM; drive enable and turnaround flag are registered alongside
  // the state so they change on the same edge as the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= RX;
      cnt     <= '0;
      drive   <= 1'b0;
      tc_turn <= 1'b0;
    end else begin
      unique case (state)
        RX: begin
          // A read request in the same cycle wins over a drive request.
          if (tp_drv_req && OE_N && tp_oe_n) begin
            if (TURN_CYC == 0) begin
              state <= TX;
              drive <= 1'b1;
            end else begin
              state   <= TURN_TX;
              cnt     <= CNT_LOAD;
              tc_turn <= 1'b1;
            end
          end
        end
        TURN_TX: begin
          if (cnt == '0) begin
            state   <= TX;
            tc_turn <= 1'b0;
            drive   <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        TX: begin
          if (!tp_drv_req) begin
            drive <= 1'b0;
            if (TURN_CYC == 0) begin
              state <= RX;
            end else begin
              state   <= TURN_RX;
              cnt     <= CNT_LOAD;
              tc_turn <= 1'b1;
            end
          end
        end
        TURN_RX: begin
          if (cnt == '0) begin
            state   <= RX;
            tc_turn <= 1'b0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= RX;
      endcase
    end
  end

  // Output register: strobes masked by the current direction, write data staged.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SIWU_N      <= 1'b1;
      WR_N        <= 1'b1;
      RD_N        <= 1'b1;
      OE_N        <= 1'b1;
      tc_conflict <= 1'b0;
      dout        <= '0;
      be_out      <= '0;
    end else begin
      SIWU_N      <= tp_siwu_n;
      WR_N        <= (state == TX) ? tp_wr_n : 1'b1;
      RD_N        <= (state == RX) ? tp_rd_n : 1'b1;
      OE_N        <= (state == RX) ? tp_oe_n : 1'b1;
      tc_conflict <= ((state != TX) && !tp_wr_n) ||
                     ((state != RX) && (!tp_rd_n || !tp_oe_n));
      dout        <= tp_data;
      be_out      <= tp_be;
    end
  end

  // Input capture chain; runs unconditionally so driven data echoes back.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < IN_STAGES; i++) in_pipe[i] <= IN_RST;
    end else begin
      in_pipe[0] <= {TXE_N, RXF_N, BE, DATA};
      for (int unsigned i = 1; i < IN_STAGES; i++) in_pipe[i] <= in_pipe[i-1];
    end
  end

  assign {tc_txe_n, tc_rxf_n, tc_be, tc_data} = in_pipe[IN_STAGES-1];
  assign tc_drv_ack = drive;
  assign DATA       = drive ? dout   : 'z;
  assign BE         = drive ? be_out : 'z;

endmodule

// File: tb/tb_fifo_mst_io_reg.sv
// Directed bench for fifo_mst_io_reg: three instances (32-bit/TURN 1/IN 1,
// 16-bit/TURN 0/IN 2, 16-bit/TURN 3/IN 2). Expected values are queued with a
// due cycle when stimulus is applied and compared when that cycle arrives.
// Hi-Z is observed by driving zeros from the bench side of the pad: any
// leftover DUT drive shows up as non-zero or X on the resolved net.
module tb_fifo_mst_io_reg;

  localparam int S_DATA = 0, S_BE = 1, S_WR = 2, S_OE = 3, S_RD = 4, S_SIWU = 5,
                 S_TCD = 6, S_TCBE = 7, S_TXE = 8, S_RXF = 9, S_ACK = 10,
                 S_TURN = 11, S_CONF = 12;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET;
  logic [31:0] tp_data;
  logic [3:0]  tp_be;
  logic        tp_drv_req, tp_siwu_n, tp_wr_n, tp_rd_n, tp_oe_n;
  logic        txe_n, rxf_n;

  // Bench-side pad drivers (the FT60x model).
  logic        ft_drv0, ft_drv1, ft_drv2;
  logic [31:0] ft_data0;
  logic [15:0] ft_data1, ft_data2;
  logic [3:0]  ft_be0;
  logic [1:0]  ft_be1, ft_be2;

  wire [31:0] data0;
  wire [15:0] data1, data2;
  wire [3:0]  be0;
  wire [1:0]  be1, be2;
  assign data0 = ft_drv0 ? ft_data0 : 'z;
  assign be0   = ft_drv0 ? ft_be0   : 'z;
  assign data1 = ft_drv1 ? ft_data1 : 'z;
  assign be1   = ft_drv1 ? ft_be1   : 'z;
  assign data2 = ft_drv2 ? ft_data2 : 'z;
  assign be2   = ft_drv2 ? ft_be2   : 'z;

  logic siwu0, wr0, rd0, oe0, txo0, rxo0, ack0, turn0, conf0;
  logic siwu1, wr1, rd1, oe1, txo1, rxo1, ack1, turn1, conf1;
  logic siwu2, wr2, rd2, oe2, txo2, rxo2, ack2, turn2, conf2;
  logic [31:0] tcd0;
  logic [15:0] tcd1, tcd2;
  logic [3:0]  tcbe0;
  logic [1:0]  tcbe1, tcbe2;

  fifo_mst_io_reg #(.WIDTH_DATA(32), .TURN_CYC(1), .IN_STAGES(1)) dut0 (
    .CLK(CLK), .RESET(RESET), .DATA(data0), .BE(be0), .TXE_N(txe_n), .RXF_N(rxf_n),
    .SIWU_N(siwu0), .WR_N(wr0), .RD_N(rd0), .OE_N(oe0),
    .tp_data(tp_data), .tp_be(tp_be), .tp_drv_req(tp_drv_req), .tp_siwu_n(tp_siwu_n),
    .tp_wr_n(tp_wr_n), .tp_rd_n(tp_rd_n), .tp_oe_n(tp_oe_n),
    .tc_data(tcd0), .tc_be(tcbe0), .tc_txe_n(txo0), .tc_rxf_n(rxo0),
    .tc_drv_ack(ack0), .tc_turn(turn0), .tc_conflict(conf0));

  fifo_mst_io_reg #(.WIDTH_DATA(16), .TURN_CYC(0), .IN_STAGES(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .DATA(data1), .BE(be1), .TXE_N(txe_n), .RXF_N(rxf_n),
    .SIWU_N(siwu1), .WR_N(wr1), .RD_N(rd1), .OE_N(oe1),
    .tp_data(tp_data[15:0]), .tp_be(tp_be[1:0]), .tp_drv_req(tp_drv_req), .tp_siwu_n(tp_siwu_n),
    .tp_wr_n(tp_wr_n), .tp_rd_n(tp_rd_n), .tp_oe_n(tp_oe_n),
    .tc_data(tcd1), .tc_be(tcbe1), .tc_txe_n(txo1), .tc_rxf_n(rxo1),
    .tc_drv_ack(ack1), .tc_turn(turn1), .tc_conflict(conf1));

  fifo_mst_io_reg #(.WIDTH_DATA(16), .TURN_CYC(3), .IN_STAGES(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .DATA(data2), .BE(be2), .TXE_N(txe_n), .RXF_N(rxf_n),
    .SIWU_N(siwu2), .WR_N(wr2), .RD_N(rd2), .OE_N(oe2),
    .tp_data(tp_data[15:0]), .tp_be(tp_be[1:0]), .tp_drv_req(tp_drv_req), .tp_siwu_n(tp_siwu_n),
    .tp_wr_n(tp_wr_n), .tp_rd_n(tp_rd_n), .tp_oe_n(tp_oe_n),
    .tc_data(tcd2), .tc_be(tcbe2), .tc_txe_n(txo2), .tc_rxf_n(rxo2),
    .tc_drv_ack(ack2), .tc_turn(turn2), .tc_conflict(conf2));

  typedef struct {
    int          due;
    int          inst;
    int          sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cycle  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] get_sig(input int inst, input int sig);
    logic [31:0] v [13];
    case (inst)
      0: v = '{data0, 32'(be0), 32'(wr0), 32'(oe0), 32'(rd0), 32'(siwu0), tcd0, 32'(tcbe0),
               32'(txo0), 32'(rxo0), 32'(ack0), 32'(turn0), 32'(conf0)};
      1: v = '{32'(data1), 32'(be1), 32'(wr1), 32'(oe1), 32'(rd1), 32'(siwu1), 32'(tcd1), 32'(tcbe1),
               32'(txo1), 32'(rxo1), 32'(ack1), 32'(turn1), 32'(conf1)};
      default: v = '{32'(data2), 32'(be2), 32'(wr2), 32'(oe2), 32'(rd2), 32'(siwu2), 32'(tcd2), 32'(tcbe2),
               32'(txo2), 32'(rxo2), 32'(ack2), 32'(turn2), 32'(conf2)};
    endcase
    return v[sig];
  endfunction

  // Queue an expectation k edges ahead of the current cycle.
  task automatic push(input int k, input int inst, input int sig, input logic [31:0] val,
                      input string tag);
    exp_t e;
    e.due  = cycle + k;
    e.inst = inst;
    e.sig  = sig;
    e.exp  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare every expectation due now.
  task automatic tick();
    logic [31:0] obs;
    int i;
    @(posedge CLK);
    #1;
    cycle++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cycle) begin
        obs = get_sig(sb[i].inst, sb[i].sig);
        n_chk++;
        assert (obs === sb[i].exp) else begin
          n_fail++;
          $error("FAIL %s (cycle %0d): observed %h expected %h", sb[i].tag, cycle, obs, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    // Reset with all tp_* low and status pads low; reset values must dominate.
    RESET = 1'b1; tp_data = '0; tp_be = '0; tp_drv_req = 1'b0;
    tp_siwu_n = 1'b0; tp_wr_n = 1'b0; tp_rd_n = 1'b0; tp_oe_n = 1'b0;
    txe_n = 1'b0; rxf_n = 1'b0;
    ft_drv0 = 1'b1; ft_data0 = '0; ft_be0 = '0;
    ft_drv1 = 1'b1; ft_data1 = '0; ft_be1 = '0;
    ft_drv2 = 1'b1; ft_data2 = '0; ft_be2 = '0;
    ticks(2);
    push(1, 0, S_DATA, 32'h0, "rst_data_hiz");
    push(1, 0, S_BE,   32'h0, "rst_be_hiz");
    push(1, 0, S_WR,   32'h1, "rst_wr_n");
    push(1, 0, S_OE,   32'h1, "rst_oe_n");
    push(1, 0, S_RD,   32'h1, "rst_rd_n");
    push(1, 0, S_SIWU, 32'h1, "rst_siwu_n");
    push(1, 0, S_TXE,  32'h1, "rst_tc_txe_n");
    push(1, 0, S_RXF,  32'h1, "rst_tc_rxf_n");
    push(1, 0, S_TCD,  32'h0, "rst_tc_data");
    push(1, 0, S_ACK,  32'h0, "rst_drv_ack");
    push(1, 0, S_TURN, 32'h0, "rst_turn");
    push(1, 0, S_CONF, 32'h0, "rst_conflict");
    tick();

    // Release reset, idle strobes; pads captured in one edge.
    RESET = 1'b0; tp_siwu_n = 1'b1; tp_wr_n = 1'b1; tp_rd_n = 1'b1; tp_oe_n = 1'b1;
    ft_data0 = 32'h1357_9BDF; ft_be0 = 4'h5;
    push(1, 0, S_TCD,  32'h1357_9BDF, "in_tc_data");
    push(1, 0, S_TCBE, 32'h5, "in_tc_be");
    push(1, 0, S_TXE,  32'h0, "in_tc_txe_n");
    push(1, 0, S_RXF,  32'h0, "in_tc_rxf_n");
    push(1, 0, S_CONF, 32'h0, "idle_conflict");
    tick();

    // Write-phase entry: one turnaround cycle, then drive.
    tp_drv_req = 1'b1; tp_data = 32'hA5A5_1234; tp_be = 4'hF; ft_drv0 = 1'b0;
    push(1, 0, S_TURN, 32'h1, "entry_turn");
    push(1, 0, S_ACK,  32'h0, "entry_ack_early");
    push(2, 0, S_ACK,  32'h1, "entry_ack");
    push(2, 0, S_TURN, 32'h0, "entry_turn_end");
    push(2, 0, S_DATA, 32'hA5A5_1234, "entry_data");
    push(2, 0, S_BE,   32'hF, "entry_be");
    push(3, 0, S_TCD,  32'hA5A5_1234, "entry_echo");
    push(3, 0, S_TCBE, 32'hF, "entry_echo_be");
    ticks(2);

    // Write strobe passes in TX; new data follows one edge later.
    tp_wr_n = 1'b0; tp_data = 32'h0F0F_F0F0;
    push(1, 0, S_WR,   32'h0, "tx_wr_n");
    push(1, 0, S_CONF, 32'h0, "tx_wr_noconf");
    push(1, 0, S_DATA, 32'h0F0F_F0F0, "tx_data2");
    push(2, 0, S_TCD,  32'h0F0F_F0F0, "tx_echo2");
    tick();

    // OE_N request in TX is masked and flagged.
    tp_wr_n = 1'b1; tp_oe_n = 1'b0;
    push(1, 0, S_OE,   32'h1, "mask_oe_n");
    push(1, 0, S_CONF, 32'h1, "mask_oe_conf");
    push(1, 0, S_WR,   32'h1, "tx_wr_n_rel");
    tick();
    tp_oe_n = 1'b1;
    push(1, 0, S_CONF, 32'h0, "mask_oe_conf_end");
    tick();

    // Write-phase exit with tp_oe_n held low.
    tp_drv_req = 1'b0; tp_oe_n = 1'b0; ft_drv0 = 1'b1; ft_data0 = '0; ft_be0 = '0;
    push(1, 0, S_DATA, 32'h0, "exit_data_hiz");
    push(1, 0, S_BE,   32'h0, "exit_be_hiz");
    push(1, 0, S_ACK,  32'h0, "exit_ack");
    push(1, 0, S_TURN, 32'h1, "exit_turn");
    push(2, 0, S_TURN, 32'h0, "exit_turn_end");
    push(1, 0, S_OE,   32'h1, "exit_oe_e1");
    push(2, 0, S_OE,   32'h1, "exit_oe_e2");
    push(3, 0, S_OE,   32'h0, "exit_oe_e3");
    push(1, 0, S_CONF, 32'h1, "exit_conf_e1");
    push(2, 0, S_CONF, 32'h1, "exit_conf_e2");
    push(3, 0, S_CONF, 32'h0, "exit_conf_e3");
    ticks(3);

    // WR_N request in RX is masked and flagged for one cycle.
    tp_oe_n = 1'b1; tp_wr_n = 1'b0;
    push(1, 0, S_WR,   32'h1, "mask_wr_n");
    push(1, 0, S_CONF, 32'h1, "mask_wr_conf");
    tick();
    tp_wr_n = 1'b1;
    push(1, 0, S_CONF, 32'h0, "mask_wr_conf_end");
    push(1, 0, S_OE,   32'h1, "rx_oe_n_rel");
    tick();

    // Simultaneous drive request and read in RX: read wins, entry waits.
    tp_drv_req = 1'b1; tp_oe_n = 1'b0;
    push(1, 0, S_OE,   32'h0, "simul_oe_n");
    push(1, 0, S_TURN, 32'h0, "simul_stay_rx");
    push(1, 0, S_ACK,  32'h0, "simul_ack");
    tick();
    tp_oe_n = 1'b1; tp_data = 32'hFFFF_FFFF; ft_drv0 = 1'b0;
    push(1, 0, S_OE,   32'h1, "simul_oe_rel");
    push(1, 0, S_TURN, 32'h0, "simul_wait");
    push(2, 0, S_TURN, 32'h1, "simul_turn");
    push(3, 0, S_ACK,  32'h1, "simul_ack_tx");
    push(3, 0, S_DATA, 32'hFFFF_FFFF, "simul_data");
    ticks(3);
    tp_wr_n = 1'b0;
    push(1, 0, S_WR, 32'h0, "tx_wr_n_ff");
    tick();

    // Reset while driving: release and strobes high on the same edge.
    RESET = 1'b1; ft_drv0 = 1'b1; ft_data0 = '0; ft_be0 = '0;
    push(1, 0, S_DATA, 32'h0, "rsttx_data_hiz");
    push(1, 0, S_WR,   32'h1, "rsttx_wr_n");
    push(1, 0, S_ACK,  32'h0, "rsttx_ack");
    push(1, 0, S_TURN, 32'h0, "rsttx_turn");
    tick();
    RESET = 1'b0; tp_wr_n = 1'b1; tp_data = 32'hC3C3_3C3C; ft_drv0 = 1'b0;
    push(1, 0, S_TURN, 32'h1, "rerun_turn");
    push(2, 0, S_ACK,  32'h1, "rerun_ack");
    push(2, 0, S_DATA, 32'hC3C3_3C3C, "rerun_data");
    ticks(2);
    tp_drv_req = 1'b0; ft_drv0 = 1'b1;
    tick();

    // Parameter sweep on the 16-bit instances.
    RESET = 1'b1; tp_siwu_n = 1'b1; tp_wr_n = 1'b1; tp_rd_n = 1'b1; tp_oe_n = 1'b1;
    ft_drv1 = 1'b1; ft_data1 = '0; ft_be1 = '0;
    ft_drv2 = 1'b1; ft_data2 = '0; ft_be2 = '0;
    ticks(2);
    RESET = 1'b0;
    ft_data1 = 16'hBEEF; ft_be1 = 2'b10; ft_data2 = 16'h1234; ft_be2 = 2'b01;
    push(1, 1, S_TCD,  32'h0, "w16t0_in_e1");
    push(2, 1, S_TCD,  32'hBEEF, "w16t0_in_e2");
    push(2, 1, S_TCBE, 32'h2, "w16t0_in_be");
    push(1, 2, S_TCD,  32'h0, "w16t3_in_e1");
    push(2, 2, S_TCD,  32'h1234, "w16t3_in_e2");
    push(2, 2, S_TCBE, 32'h1, "w16t3_in_be");
    ticks(2);

    tp_drv_req = 1'b1; tp_data = 32'h0000_7E57; tp_be = 4'h3; ft_drv1 = 1'b0; ft_drv2 = 1'b0;
    push(1, 1, S_ACK,  32'h1, "w16t0_ack");
    push(1, 1, S_DATA, 32'h7E57, "w16t0_data");
    push(1, 1, S_BE,   32'h3, "w16t0_be");
    push(1, 1, S_TURN, 32'h0, "w16t0_noturn");
    push(3, 1, S_TCD,  32'h7E57, "w16t0_echo");
    push(1, 2, S_ACK,  32'h0, "w16t3_ack_e1");
    push(1, 2, S_TURN, 32'h1, "w16t3_turn_e1");
    push(3, 2, S_ACK,  32'h0, "w16t3_ack_e3");
    push(3, 2, S_TURN, 32'h1, "w16t3_turn_e3");
    push(4, 2, S_ACK,  32'h1, "w16t3_ack_e4");
    push(4, 2, S_TURN, 32'h0, "w16t3_turn_e4");
    push(4, 2, S_DATA, 32'h7E57, "w16t3_data");
    push(6, 2, S_TCD,  32'h7E57, "w16t3_echo");
    push(6, 2, S_TCBE, 32'h3, "w16t3_echo_be");
    ticks(6);

    tp_drv_req = 1'b0; tp_oe_n = 1'b0;
    ft_drv1 = 1'b1; ft_data1 = '0; ft_be1 = '0;
    ft_drv2 = 1'b1; ft_data2 = '0; ft_be2 = '0;
    push(1, 1, S_DATA, 32'h0, "w16t0_hiz");
    push(1, 1, S_ACK,  32'h0, "w16t0_ack_off");
    push(1, 1, S_TURN, 32'h0, "w16t0_exit_noturn");
    push(1, 1, S_OE,   32'h1, "w16t0_oe_e1");
    push(2, 1, S_OE,   32'h0, "w16t0_oe_e2");
    push(1, 2, S_DATA, 32'h0, "w16t3_hiz");
    push(1, 2, S_ACK,  32'h0, "w16t3_ack_off");
    push(1, 2, S_TURN, 32'h1, "w16t3_exit_turn");
    push(3, 2, S_TURN, 32'h1, "w16t3_exit_turn_e3");
    push(4, 2, S_TURN, 32'h0, "w16t3_exit_turn_e4");
    push(4, 2, S_OE,   32'h1, "w16t3_oe_e4");
    push(5, 2, S_OE,   32'h0, "w16t3_oe_e5");
    ticks(5);

    // Anything still queued was never reached.
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
